stream_demux_router: RTL and testbench

- Parametrised, handshaked successor to the 3-way operand demux.
- Routes a burst of data words from one input stream (DMA/load path) to one of NUM_CH destination buffers (IFM, WGT, BIAS, ...).
- Each burst is announced by a config command that gives a destination code and a beat count.
- Provides valid/ready back-pressure per channel, a registered output stage, end-of-burst marking, and a drop mode for illegal destinations.

---
 rtl/operand_route_pkg.sv | 21 ++
 rtl/stream_out_reg.sv | 67 ++++++
 rtl/stream_demux_router.sv | 166 ++++++++++++++++
 tb/tb_stream_demux_router.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_route_pkg.sv
// Shared definitions for the operand routing blocks.
//
// Holds the destination codes used by both the legacy 3-way operand demux
// and the handshaked stream_demux_router, plus the router FSM state type.
// Code 0 is reserved as "no destination". Code k (k >= 1) selects
// destination channel k-1.
package operand_route_pkg;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_IFM  = 2'b01;
    localparam logic [1:0] CODE_WGT  = 2'b10;
    localparam logic [1:0] CODE_BIAS = 2'b11;

    // Router FSM states. The encoding is visible on the router's dbg_state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } route_state_e;

endpackage

// File: rtl/stream_out_reg.sv
// One-slot valid/ready output register with an end-of-burst flag.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   load                  write load_data/load_last into the slot this cycle
//   load_data, load_last  beat and its last flag
//   out_ready             downstream sink ready
//   out_valid             slot holds a beat
//   out_data, out_last    slot contents; both read 0 while the slot is empty
//
// Handshake: a beat leaves the slot when out_valid && out_ready. The caller
// only asserts load when the slot is empty or is draining in the same cycle.
// A load in the same cycle as a drain wins, so the slot stays full with the
// new beat.
module stream_out_reg
    import operand_route_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    logic                  valid_q, valid_d;
    logic                  last_q,  last_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
        end else if (valid_q && out_ready) begin
            // Data is cleared on drain so an empty slot always presents zeros.
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/stream_demux_router.sv
// Burst router: steers beats from one input stream to one of NUM_CH
// destination channels, one burst per config command.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cfg_valid/cfg_ready     burst command handshake; cfg_sel = destination
//                           code (1..NUM_CH legal), cfg_len = beat count
//   in_valid/in_ready       input beat handshake, in_data = beat
//   out_valid/out_ready     per-channel beat handshake
//   out_data                channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_last                per-channel final beat of burst
//   busy                    FSM not in IDLE
//   done                    one-cycle pulse when the input side of a burst completes
//   err                     pulses with done for a burst to an illegal code
//   dbg_state               current FSM state (route_state_e encoding)
//
// Handshake rule for all three interfaces: a transfer happens on a rising
// clock edge where valid and ready are both high; valid never depends on ready.
// in_ready does depend on out_ready of the selected channel (pass-through when
// that channel's slot is full).
module stream_demux_router
    import operand_route_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int SEL_WIDTH  = 2,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [SEL_WIDTH-1:0]         cfg_sel,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   dbg_state
);

    route_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [NUM_CH-1:0]     ch_oh_q, ch_oh_d;
    logic                  done_q,  done_d;
    logic                  err_q,   err_d;
    // Holds cfg_ready low until the first clock edge after reset release.
    logic                  init_q;

    logic [NUM_CH-1:0]     cfg_oh;
    logic                  cfg_legal;
    logic [NUM_CH-1:0]     load;
    logic                  last_beat;

    // Decode the destination code to a one-hot channel mask; an all-zero
    // mask means the code is illegal (0 or above NUM_CH).
    always_comb begin
        cfg_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cfg_oh[k] = (32'(cfg_sel) == 32'(k + 1));
        end
        cfg_legal = |cfg_oh;
    end

    assign last_beat = (cnt_q == LEN_WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_oh_d   = ch_oh_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        load      = '0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = init_q;
                if (cfg_valid && init_q) begin
                    cnt_d   = cfg_len;
                    ch_oh_d = cfg_oh;
                    if (cfg_len == '0) begin
                        done_d = 1'b1;
                        err_d  = !cfg_legal;
                    end else if (cfg_legal) begin
                        state_d = ST_ROUTE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_ROUTE: begin
                // Accept only if the selected slot is empty or draining now.
                in_ready = |(ch_oh_q & (~out_valid | out_ready));
                if (in_valid && in_ready) begin
                    load  = ch_oh_q;
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ch_oh_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_oh_q <= ch_oh_d;
            done_q  <= done_d;
            err_q   <= err_d;
            init_q  <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        stream_out_reg #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_out_reg (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .load_last (last_beat),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .out_last  (out_last[k])
        );
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_demux_router.sv
// Bench for stream_demux_router. Inputs change 1 time unit after the rising
// edge; outputs are sampled and checked on the falling edge.
module tb_stream_demux_router;
    import operand_route_pkg::*;

    localparam int DW  = 32;
    localparam int NCH = 3;
    localparam int SW  = 2;
    localparam int LW  = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [SW-1:0]       cfg_sel = '0;
    logic [LW-1:0]       cfg_len = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DW-1:0]       in_data = '0;
    logic [NCH-1:0]      out_valid;
    logic [NCH-1:0]      out_ready = '1;
    logic [NCH*DW-1:0]   out_data;
    logic [NCH-1:0]      out_last;
    logic                busy;
    logic                done;
    logic                err;
    logic [1:0]          dbg_state;

    always #5 clk = ~clk;

    stream_demux_router #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .SEL_WIDTH(SW), .LEN_WIDTH(LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Burst-level view: an active burst has a destination and a remaining
    // beat count; each channel holds the queue of beats it has been given
    // but not yet delivered ({last, data}).
    logic [DW:0] exp_q[NCH][$];
    bit          m_init   = 1'b0;
    bit          m_active = 1'b0;
    bit          m_legal  = 1'b0;
    int          m_ch     = 0;
    int          m_rem    = 0;
    bit          m_done   = 1'b0;
    bit          m_err    = 1'b0;

    // Observations of DUT activity, pinned by literal checks in the tests.
    int          obs_done = 0;
    int          obs_err  = 0;
    int          obs_beats[NCH];
    logic [DW-1:0] obs_last_data[NCH];

    initial begin
        for (int k = 0; k < NCH; k++) begin
            obs_beats[k]     = 0;
            obs_last_data[k] = '0;
        end
    end

    always @(negedge clk) begin : cmp
        logic [NCH-1:0]    e_valid;
        logic [NCH-1:0]    e_last;
        logic [NCH*DW-1:0] e_data;
        bit                e_in_ready;
        bit                e_cfg_ready;
        bit                legal;
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) exp_q[k].delete();
            m_init   = 1'b0;
            m_active = 1'b0;
            m_legal  = 1'b0;
            m_ch     = 0;
            m_rem    = 0;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end
        e_cfg_ready = m_init && !m_active;
        e_in_ready  = m_active && (!m_legal || exp_q[m_ch].size() == 0 || out_ready[m_ch]);
        e_valid = '0;
        e_last  = '0;
        e_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (exp_q[k].size() != 0) begin
                e_valid[k]            = 1'b1;
                e_last[k]             = exp_q[k][0][DW];
                e_data[k*DW +: DW]    = exp_q[k][0][DW-1:0];
            end
        end
        chk("cfg_ready", cfg_ready, e_cfg_ready);
        chk("in_ready",  in_ready,  e_in_ready);
        chk("busy",      busy,      m_active);
        chk("done",      done,      m_done);
        chk("err",       err,       m_err);
        chk("out_valid", out_valid, e_valid);
        chk("out_last",  out_last,  e_last);
        chk("out_data",  out_data,  e_data);

        if (done) obs_done++;
        if (err)  obs_err++;
        for (int k = 0; k < NCH; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                obs_beats[k]++;
                if (out_last[k]) obs_last_data[k] = out_data[k*DW +: DW];
            end
        end

        // Advance the model to the state after the coming rising edge.
        if (rst_n) begin
            m_done = 1'b0;
            m_err  = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (e_valid[k] && out_ready[k]) void'(exp_q[k].pop_front());
            end
            if (e_in_ready && in_valid) begin
                if (m_legal) exp_q[m_ch].push_back({(m_rem == 1), in_data});
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_err    = !m_legal;
                end
            end else if (e_cfg_ready && cfg_valid) begin
                legal = (int'(cfg_sel) >= 1) && (int'(cfg_sel) <= NCH);
                if (cfg_len == 0) begin
                    m_done = 1'b1;
                    m_err  = !legal;
                end else begin
                    m_active = 1'b1;
                    m_legal  = legal;
                    m_ch     = legal ? int'(cfg_sel) - 1 : 0;
                    m_rem    = int'(cfg_len);
                end
            end
            m_init = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cfg(input logic [SW-1:0] sel, input logic [LW-1:0] len, output int cycles);
        bit hs;
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_len   = len;
        cycles    = 0;
        hs        = 1'b0;
        do begin
            @(negedge clk);
            hs = cfg_ready;
            @(posedge clk);
            #1;
            cycles++;
        end while (!hs && cycles < 200);
        cfg_valid = 1'b0;
        chk("cfg_handshake_in_time", hs, 1'b1);
    endtask

    task automatic send_beat(input logic [DW-1:0] data, output int cycles);
        bit hs;
        in_valid = 1'b1;
        in_data  = data;
        cycles   = 0;
        hs       = 1'b0;
        do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end while (!hs && cycles < 200);
        in_valid = 1'b0;
        in_data  = $urandom;   // junk while idle: must be ignored
        chk("beat_handshake_in_time", hs, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int c;
        int b0[NCH];
        int d0;
        int e0;

        // Reset state, sampled while reset is held.
        #1;
        chk("rst_cfg_ready", cfg_ready, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_out_valid", out_valid, 3'b000);
        chk("rst_out_data",  out_data,  96'h0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_done_err",  {done, err}, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        chk("cfg_ready_after_rst", cfg_ready, 1'b1);
        chk("state_idle_after_rst", dbg_state, 2'd0);

        // T1: WGT burst of 4 with sinks always ready.
        b0 = obs_beats; d0 = obs_done; e0 = obs_err;
        send_cfg(CODE_WGT, 16'd4, c);
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i), c);
        idle(4);
        chk("t1_wgt_beats", obs_beats[1] - b0[1], 4);
        chk("t1_wgt_last",  obs_last_data[1], 32'hA3);
        chk("t1_ifm_beats", obs_beats[0] - b0[0], 0);
        chk("t1_bias_beats", obs_beats[2] - b0[2], 0);
        chk("t1_done", obs_done - d0, 1);
        chk("t1_err",  obs_err - e0, 0);

        // T2: IFM burst of 3, sink stalls for 3 cycles after beat 1 lands.
        b0 = obs_beats; d0 = obs_done;
        send_cfg(CODE_IFM, 16'd3, c);
        send_beat(32'hB0, c);
        out_ready[0] = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready[0] = 1'b1;
            end
        join_none
        send_beat(32'hB1, c);
        chk("t2_stall_cycles", c, 4);
        send_beat(32'hB2, c);
        idle(4);
        chk("t2_ifm_beats", obs_beats[0] - b0[0], 3);
        chk("t2_ifm_last",  obs_last_data[0], 32'hB2);
        chk("t2_done", obs_done - d0, 1);

        // T3: illegal code 0 drops 2 beats, then BIAS gets 1 beat.
        b0 = obs_beats; d0 = obs_done; e0 = obs_err;
        send_cfg(CODE_NONE, 16'd2, c);
        send_beat(32'hDEAD0001, c);
        send_beat(32'hDEAD0002, c);
        send_cfg(CODE_BIAS, 16'd1, c);
        send_beat(32'hC0, c);
        idle(4);
        chk("t3_err",  obs_err - e0, 1);
        chk("t3_done", obs_done - d0, 2);
        chk("t3_bias_beats", obs_beats[2] - b0[2], 1);
        chk("t3_bias_last",  obs_last_data[2], 32'hC0);
        chk("t3_other_beats", (obs_beats[0] - b0[0]) + (obs_beats[1] - b0[1]), 0);

        // T4: zero-length burst, next cfg accepted on the following cycle.
        b0 = obs_beats; d0 = obs_done; e0 = obs_err;
        send_cfg(CODE_IFM, 16'd0, c);
        send_cfg(CODE_BIAS, 16'd1, c);
        chk("t4_next_cfg_cycles", c, 1);
        send_beat(32'hC1, c);
        idle(4);
        chk("t4_done", obs_done - d0, 2);
        chk("t4_err",  obs_err - e0, 0);
        chk("t4_ifm_beats", obs_beats[0] - b0[0], 0);
        chk("t4_bias_last", obs_last_data[2], 32'hC1);

        // T5: IFM last beat held while a WGT burst flows.
        b0 = obs_beats;
        send_cfg(CODE_IFM, 16'd2, c);
        send_beat(32'hD0, c);
        send_beat(32'hD1, c);
        out_ready[0] = 1'b0;
        send_cfg(CODE_WGT, 16'd2, c);
        send_beat(32'hE0, c);
        send_beat(32'hE1, c);
        idle(3);
        chk("t5_ifm_held_valid", out_valid[0], 1'b1);
        chk("t5_ifm_held_last",  out_last[0], 1'b1);
        chk("t5_ifm_held_data",  out_data[31:0], 32'hD1);
        chk("t5_wgt_beats", obs_beats[1] - b0[1], 2);
        chk("t5_ifm_beats_held", obs_beats[0] - b0[0], 1);
        out_ready[0] = 1'b1;
        idle(3);
        chk("t5_ifm_beats", obs_beats[0] - b0[0], 2);
        chk("t5_ifm_last",  obs_last_data[0], 32'hD1);

        // T6: reset after 2 of 5 beats.
        b0 = obs_beats; d0 = obs_done;
        send_cfg(CODE_IFM, 16'd5, c);
        send_beat(32'hF0, c);
        send_beat(32'hF1, c);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 3'b000);
        chk("t6_rst_out_data",  out_data, 96'h0);
        chk("t6_rst_out_last",  out_last, 3'b000);
        chk("t6_rst_ctrl", {cfg_ready, in_ready, busy, done, err}, 5'b00000);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("t6_cfg_ready_after_rst", cfg_ready, 1'b1);
        chk("t6_no_done", obs_done - d0, 0);
        d0 = obs_done;
        send_cfg(CODE_WGT, 16'd2, c);
        send_beat(32'h60, c);
        send_beat(32'h61, c);
        idle(4);
        chk("t6_wgt_beats", obs_beats[1] - b0[1], 2);
        chk("t6_wgt_last",  obs_last_data[1], 32'h61);
        chk("t6_done", obs_done - d0, 1);

        for (int k = 0; k < NCH; k++) chk($sformatf("end_queue_empty_%0d", k), exp_q[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
